// File: rtl/audio_out_pkg.sv
// audio_out_pkg: register map, sample/slot widths and slot bit helper for audio_i2s_out
package audio_out_pkg;
  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_CTRL   = 8'h04;
  localparam logic [7:0] ADDR_UCNT   = 8'h08;
  localparam logic [7:0] ADDR_LEFT   = 8'h10;
  localparam logic [7:0] ADDR_RIGHT  = 8'h20;
  localparam int SAMPLE_W = 16;
  localparam int SLOT_W   = 32;
  // Serial bit at slot position b: MSB-first in bits 1..SAMPLE_W, zero elsewhere
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] s, input logic [4:0] b);
    logic [4:0] i;
    i = 5'(SAMPLE_W) - b;
    return (b >= 5'd1 && b <= 5'(SAMPLE_W)) ? s[i[3:0]] : 1'b0;
  endfunction
endpackage

// File: rtl/audio_i2s_out_if.sv
// audio_i2s_out_if: command/response bus between host and audio_i2s_out
interface audio_i2s_out_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_id;
  logic        cmd_write;
  logic [7:0]  cmd_address;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_data;
  modport master(output cmd_valid, cmd_id, cmd_write, cmd_address, cmd_data,
                 input cmd_ready, rsp_valid, rsp_id, rsp_data);
  modport slave(input cmd_valid, cmd_id, cmd_write, cmd_address, cmd_data,
                output cmd_ready, rsp_valid, rsp_id, rsp_data);
endinterface

// File: rtl/audio_i2s_out_sample_fifo.sv
// sample_fifo: synchronous DEPTH x 16 show-ahead FIFO with push/pop/flush and fill level
module sample_fifo import audio_out_pkg::*; #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [SAMPLE_W-1:0] din,
  output logic [SAMPLE_W-1:0] dout,
  output logic [LW-1:0]       level,
  output logic                full,
  output logic                empty
);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic do_push, do_pop;
  logic [SAMPLE_W-1:0] mem [DEPTH];
  // Pointer/level update; flush wins over a simultaneous push or pop
  always_comb begin
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
    wr_d    = flush ? '0 : wr_q + AW'(do_push);
    rd_d    = flush ? '0 : rd_q + AW'(do_pop);
    lvl_d   = flush ? '0 : lvl_q + LW'(do_push) - LW'(do_pop);
  end
  // Pointer and level state
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  // Sample storage, no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wr_q] <= din;
  assign dout  = mem[rd_q];
  assign level = lvl_q;
  assign full  = lvl_q == LW'(DEPTH);
  assign empty = lvl_q == '0;
endmodule

// File: rtl/audio_i2s_out.sv
// audio_i2s_out: register-fed stereo I2S transmitter; AUDIO_OUT_UNDERRUN_COUNT_EN adds an underrun-frame counter at 0x08
module audio_i2s_out import audio_out_pkg::*; #(
  parameter int DEPTH       = 64,
  parameter int START_LEVEL = 40,
  parameter int BCLK_HALF   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  audio_i2s_out_if.slave   bus,
  output logic             i2s_bclk,
  output logic             i2s_lrclk,
  output logic             i2s_sdata,
  output logic             playing
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(BCLK_HALF + 1);
  logic [SAMPLE_W-1:0] l_dout, r_dout;
  logic [LW-1:0] l_lvl, r_lvl;
  logic l_full, r_full, l_empty, r_empty;
  logic stall, accept, wr, push_l, push_r, flush, clr_ur;
  logic tick, fall, frame_end, start, play_now, have, pop, ur_frame;
  logic [31:0] status, rdata;
  logic [DW-1:0] div_q, div_d;
  logic [5:0] bit_q, bit_d;
  logic bclk_q, bclk_d, lr_q, lr_d, sdata_q, sdata_d, playing_q, playing_d, ur_q, ur_d;
  logic rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
`ifdef AUDIO_OUT_UNDERRUN_COUNT_EN
  logic [15:0] ucnt_q, ucnt_d;
`endif
  sample_fifo #(.DEPTH(DEPTH)) u_left (
    .clk, .resetn, .push(push_l), .pop, .flush, .din(bus.cmd_data[SAMPLE_W-1:0]),
    .dout(l_dout), .level(l_lvl), .full(l_full), .empty(l_empty));
  sample_fifo #(.DEPTH(DEPTH)) u_right (
    .clk, .resetn, .push(push_r), .pop, .flush, .din(bus.cmd_data[SAMPLE_W-1:0]),
    .dout(r_dout), .level(r_lvl), .full(r_full), .empty(r_empty));
  // Command decode; only sample writes to a full FIFO stall the bus
  always_comb begin
    stall  = bus.cmd_write && ((bus.cmd_address == ADDR_LEFT && l_full) ||
                               (bus.cmd_address == ADDR_RIGHT && r_full));
    accept = bus.cmd_valid && !stall;
    wr     = accept && bus.cmd_write;
    push_l = wr && bus.cmd_address == ADDR_LEFT;
    push_r = wr && bus.cmd_address == ADDR_RIGHT;
    flush  = wr && bus.cmd_address == ADDR_CTRL && bus.cmd_data[0];
    clr_ur = wr && bus.cmd_address == ADDR_CTRL && (bus.cmd_data[0] || bus.cmd_data[1]);
  end
  // Read data and one-cycle response
  always_comb begin
    status = {ur_q, playing_q, 5'b0, 9'(r_lvl), 7'b0, 9'(l_lvl)};
    rdata  = bus.cmd_address == ADDR_STATUS ? status : 32'h0;
`ifdef AUDIO_OUT_UNDERRUN_COUNT_EN
    rdata  = bus.cmd_address == ADDR_UCNT ? {16'h0, ucnt_q} : rdata;
`endif
    rsp_valid_d = accept;
    rsp_id_d    = accept && bus.cmd_id;
    rsp_data_d  = (accept && !bus.cmd_write) ? rdata : 32'h0;
  end
  // Bit clock divider, frame position and playback sequencing
  always_comb begin
    tick      = div_q == DW'(BCLK_HALF - 1);
    div_d     = tick ? '0 : div_q + 1'b1;
    bclk_d    = bclk_q ^ tick;
    fall      = tick && bclk_q;
    bit_d     = fall ? bit_q + 6'd1 : bit_q;
    frame_end = fall && bit_q == 6'd63;
    start     = l_lvl >= LW'(START_LEVEL) && r_lvl >= LW'(START_LEVEL);
    play_now  = playing_q || start;
    have      = !l_empty && !r_empty;
    pop       = frame_end && play_now && have && !flush;
    ur_frame  = frame_end && play_now && !have && !flush;
    playing_d = flush ? 1'b0 : (frame_end && start) ? 1'b1 : playing_q;
    ur_d      = clr_ur ? 1'b0 : ur_frame ? 1'b1 : ur_q;
    left_d    = frame_end ? (pop ? l_dout : '0) : left_q;
    right_d   = frame_end ? (pop ? r_dout : '0) : right_q;
    lr_d      = fall ? bit_d[5] : lr_q;
    sdata_d   = fall ? slot_bit(bit_d[5] ? right_q : left_q, bit_d[4:0]) : sdata_q;
`ifdef AUDIO_OUT_UNDERRUN_COUNT_EN
    ucnt_d    = clr_ur ? 16'h0 : (ur_frame && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
`endif
  end
  // All block state; reset restarts framing at left-slot bit 0
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      div_q       <= '0;
      bit_q       <= '0;
      bclk_q      <= 1'b0;
      lr_q        <= 1'b0;
      sdata_q     <= 1'b0;
      playing_q   <= 1'b0;
      ur_q        <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
`ifdef AUDIO_OUT_UNDERRUN_COUNT_EN
      ucnt_q      <= '0;
`endif
    end else begin
      div_q       <= div_d;
      bit_q       <= bit_d;
      bclk_q      <= bclk_d;
      lr_q        <= lr_d;
      sdata_q     <= sdata_d;
      playing_q   <= playing_d;
      ur_q        <= ur_d;
      left_q      <= left_d;
      right_q     <= right_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
`ifdef AUDIO_OUT_UNDERRUN_COUNT_EN
      ucnt_q      <= ucnt_d;
`endif
    end
  assign bus.cmd_ready = !stall;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign i2s_bclk      = bclk_q;
  assign i2s_lrclk     = lr_q;
  assign i2s_sdata     = sdata_q;
  assign playing       = playing_q;
endmodule

// File: tb/tb_audio_i2s_out.sv
// tb_audio_i2s_out: directed self-checking bench for audio_i2s_out
module tb_audio_i2s_out;
  import audio_out_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic bclk, lrclk, sdata, playing;
  int n_checks = 0;
  int n_err = 0;
`ifdef AUDIO_OUT_UNDERRUN_COUNT_EN
  localparam logic [31:0] UCNT_EXP = 32'd2;
`else
  localparam logic [31:0] UCNT_EXP = 32'd0;
`endif
  audio_i2s_out_if bus();
  audio_i2s_out dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata), .playing(playing));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d, input logic id,
                      output logic [31:0] rdat, output int waited, output logic rv, output logic rid);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_address = a;
    bus.cmd_data = d;
    bus.cmd_id = id;
    waited = 0;
    #1;
    while (!bus.cmd_ready && waited < 2000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 2000) check("ready_timeout", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    rdat = bus.rsp_data;
    rv = bus.rsp_valid;
    rid = bus.rsp_id;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    int w;
    logic v, i;
    xfer(1'b1, a, d, 1'b0, r, w, v, i);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int w;
    logic v, i;
    xfer(1'b0, a, 32'h0, 1'b1, r, w, v, i);
    check({tag, "_rsp"}, {v, i}, 2'b11);
    check(tag, r, exp);
  endtask

  task automatic wait_frames(input int n);
    logic p;
    int c;
    for (int k = 0; k < n; k++) begin
      p = lrclk;
      c = 0;
      while (c < 2000) begin
        @(negedge clk);
        c++;
        if (p && !lrclk) break;
        p = lrclk;
      end
      if (c >= 2000) check("frame_timeout", c, 0);
    end
  endtask

  task automatic capture(output logic [63:0] sd, output logic [63:0] lr, output logic [63:0] bc);
    wait_frames(1);
    repeat (7) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      sd[63-i] = sdata;
      lr[63-i] = lrclk;
      bc[63-i] = bclk;
      if (i < 63) repeat (10) @(negedge clk);
    end
  endtask

  initial begin
    logic [63:0] sd, lr, bc;
    logic [31:0] r;
    int w, fb, fl, n;
    logic v, i;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_address = 8'h0;
    bus.cmd_data = 32'h0;
    bus.cmd_id = 1'b0;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, 34'h0);
    check("rst_i2s", {bclk, lrclk, sdata, playing}, 4'h0);
    resetn = 1'b1;
    rd_check("status_init", ADDR_STATUS, 32'h0);
    // 40 left + 39 right: not enough to start
    for (int k = 0; k < 40; k++) wr(ADDR_LEFT, 32'h0000_1234);
    for (int k = 0; k < 39; k++) wr(ADDR_RIGHT, 32'h0000_ABCD);
    wait_frames(2);
    check("short_playing", playing, 0);
    rd_check("short_status", ADDR_STATUS, 32'h0027_0028);
    rd_check("unmapped_rd", 8'h0C, 32'h0);
    wr(8'h30, 32'hFFFF_FFFF);
    rd_check("unmapped_wr", ADDR_STATUS, 32'h0027_0028);
    rd_check("ucnt_zero", ADDR_UCNT, 32'h0);
    wr(ADDR_CTRL, 32'h1);
    rd_check("flush_status", ADDR_STATUS, 32'h0);
    // Start playback and check the first frame
    for (int k = 0; k < 40; k++) wr(ADDR_LEFT, 32'h0000_1234);
    for (int k = 0; k < 40; k++) wr(ADDR_RIGHT, 32'h0000_ABCD);
    capture(sd, lr, bc);
    check("frame1_sdata", sd, {1'b0, 16'h1234, 15'h0, 1'b0, 16'hABCD, 15'h0});
    check("frame1_lrclk", lr, {32'h0, 32'hFFFF_FFFF});
    check("frame1_bclk", bc, {64{1'b1}});
    check("frame1_playing", playing, 1);
    // Drain all 40 pairs, then underrun
    wait_frames(39);
    rd_check("drained_status", ADDR_STATUS, 32'h4000_0000);
    capture(sd, lr, bc);
    check("underrun_sdata", sd, 64'h0);
    wait_frames(1);
    rd_check("underrun_status", ADDR_STATUS, 32'hC000_0000);
    rd_check("underrun_count", ADDR_UCNT, UCNT_EXP);
    wr(ADDR_CTRL, 32'h2);
    rd_check("clr_ur_status", ADDR_STATUS, 32'h4000_0000);
    rd_check("clr_ur_count", ADDR_UCNT, 32'h0);
    // Flush during playback
    for (int k = 0; k < 3; k++) wr(ADDR_LEFT, 32'h0000_1111);
    for (int k = 0; k < 3; k++) wr(ADDR_RIGHT, 32'h0000_2222);
    wr(ADDR_CTRL, 32'h1);
    rd_check("flush_play_status", ADDR_STATUS, 32'h0);
    check("flush_playing", playing, 0);
    capture(sd, lr, bc);
    check("flush_sdata", sd, 64'h0);
    // Full left FIFO stalls until the first pop
    for (int k = 0; k < 64; k++) wr(ADDR_LEFT, 32'h0000_8001);
    for (int k = 0; k < 39; k++) wr(ADDR_RIGHT, 32'h0000_0F0F);
    wait_frames(1);
    rd_check("full_status", ADDR_STATUS, 32'h0027_0040);
    wr(ADDR_RIGHT, 32'h0000_0F0F);
    xfer(1'b1, ADDR_LEFT, 32'h0000_7777, 1'b1, r, w, v, i);
    check("full_held", w > 100, 1);
    check("full_rsp", {v, i}, 2'b11);
    rd_check("full_after", ADDR_STATUS, 32'h4027_0040);
    // Asynchronous reset mid-frame, then framing restart
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_out", {bclk, lrclk, sdata, playing, bus.rsp_valid, bus.rsp_id}, 6'h0);
    check("async_rst_ready", bus.cmd_ready, 1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    n = 0;
    fb = 0;
    fl = 0;
    while ((fb == 0 || fl == 0) && n < 1000) begin
      @(negedge clk);
      n++;
      if (fb == 0 && bclk) fb = n;
      if (fl == 0 && lrclk) fl = n;
    end
    check("restart_bclk", fb, 5);
    check("restart_lrclk", fl, 320);
    rd_check("restart_status", ADDR_STATUS, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
